// File: rtl/mem_stage.sv
// mem_stage: load/store unit between exe_mem and mem_wb with a two-state bus FSM.
// Optional misalignment trap compiled in by MEM_MISALIGN_CHECK_EN.
module mem_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        mem_en_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        out_valid_o,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic        misalign_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        we_q, we_d;
  logic        req_q, req_d, bwe_q, bwe_d;
  logic [31:0] baddr_q, baddr_d, bwdata_q, bwdata_d;
  logic [3:0]  be_q, be_d;
  logic        out_valid_q, out_valid_d, rwe_q, rwe_d, mis_q, mis_d;
  logic [4:0]  rwaddr_q, rwaddr_d;
  logic [31:0] rwdata_q, rwdata_d;
  logic        mis, accept;
  logic [1:0]  size;
  logic [3:0]  st_be;
  logic [31:0] st_wd, load_val;
  logic [7:0]  lb;
  logic [15:0] lh;
  assign size   = mem_op_i[1:0];
  assign accept = in_valid_i && state_q == IDLE;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = mem_en_i && ((size == 2'b01 && mem_addr_i[0]) || (size[1] && mem_addr_i[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif
  // size 2'b11 falls through to word everywhere
  assign st_be = size == 2'b00 ? 4'b0001 << mem_addr_i[1:0] :
                 size == 2'b01 ? (mem_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_wd = size == 2'b00 ? {4{mem_data_i[7:0]}} :
                 size == 2'b01 ? {2{mem_data_i[15:0]}} : mem_data_i;
  assign lb = dbus_rdata_i[{off_q, 3'b000} +: 8];
  assign lh = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
  assign load_val = op_q[1:0] == 2'b00 ? {{24{lb[7] & ~op_q[2]}}, lb} :
                    op_q[1:0] == 2'b01 ? {{16{lh[15] & ~op_q[2]}}, lh} : dbus_rdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? ((accept && mem_en_i && !mis) ? BUSY : IDLE)
                              : (dbus_ack_i ? IDLE : BUSY);
  end
  always_comb begin
    op_d = op_q; off_d = off_q; waddr_d = waddr_q; we_d = we_q;
    req_d = req_q; bwe_d = bwe_q; baddr_d = baddr_q; bwdata_d = bwdata_q; be_d = be_q;
    out_valid_d = 1'b0; rwaddr_d = rwaddr_q; rwe_d = rwe_q; rwdata_d = rwdata_q; mis_d = mis_q;
    if (accept && !mem_en_i) begin
      out_valid_d = 1'b1;
      rwaddr_d    = reg_waddr_i;
      rwe_d       = reg_we_i && reg_waddr_i != 5'd0;
      rwdata_d    = reg_wdata_i;
      mis_d       = 1'b0;
    end else if (accept && mis) begin
      out_valid_d = 1'b1;
      rwaddr_d    = reg_waddr_i;
      rwe_d       = 1'b0;
      mis_d       = 1'b1;
    end else if (accept) begin
      op_d     = mem_op_i;
      off_d    = mem_addr_i[1:0];
      waddr_d  = reg_waddr_i;
      we_d     = reg_we_i;
      req_d    = 1'b1;
      bwe_d    = mem_op_i[3];
      baddr_d  = {mem_addr_i[31:2], 2'b00};
      bwdata_d = st_wd;
      be_d     = mem_op_i[3] ? st_be : 4'b1111;
    end else if (state_q == BUSY && dbus_ack_i) begin
      req_d       = 1'b0;
      out_valid_d = 1'b1;
      rwaddr_d    = waddr_q;
      rwe_d       = !op_q[3] && we_q && waddr_q != 5'd0;
      rwdata_d    = op_q[3] ? rwdata_q : load_val;
      mis_d       = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q <= '0; off_q <= '0; waddr_q <= '0; we_q <= 1'b0;
      req_q <= 1'b0; bwe_q <= 1'b0; baddr_q <= '0; bwdata_q <= '0; be_q <= '0;
      out_valid_q <= 1'b0; rwaddr_q <= '0; rwe_q <= 1'b0; rwdata_q <= '0; mis_q <= 1'b0;
    end else begin
      op_q <= op_d; off_q <= off_d; waddr_q <= waddr_d; we_q <= we_d;
      req_q <= req_d; bwe_q <= bwe_d; baddr_q <= baddr_d; bwdata_q <= bwdata_d; be_q <= be_d;
      out_valid_q <= out_valid_d; rwaddr_q <= rwaddr_d; rwe_q <= rwe_d; rwdata_q <= rwdata_d; mis_q <= mis_d;
    end
  end
  assign in_ready_o   = state_q == IDLE;
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = bwe_q;
  assign dbus_addr_o  = baddr_q;
  assign dbus_wdata_o = bwdata_q;
  assign dbus_be_o    = be_q;
  assign out_valid_o  = out_valid_q;
  assign reg_waddr_o  = rwaddr_q;
  assign reg_we_o     = rwe_q;
  assign reg_wdata_o  = rwdata_q;
  assign misalign_o   = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random load/store checks against a byte-level reference model.
module tb_mem_stage;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic [4:0]  reg_waddr_i = '0;
  logic        reg_we_i = 1'b0;
  logic [31:0] reg_wdata_i = '0;
  logic        mem_en_i = 1'b0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] mem_addr_i = '0, mem_data_i = '0;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_ack_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic        out_valid_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        misalign_o;
  int total = 0, bad = 0;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_en_i(mem_en_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .out_valid_o(out_valid_o), .reg_waddr_o(reg_waddr_o),
    .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic int offs(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(op[1:0]);
    logic [31:0] mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    logic [31:0] v = (rd >> (8 * offs(op[1:0], a))) & mask;
    if (!op[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    int n = nbytes(op[1:0]);
    return 4'(((1 << n) - 1) << offs(op[1:0], a));
  endfunction

  function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] d);
    int n = nbytes(op[1:0]);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8 * i +: 8] = d[8 * (i % n) +: 8];
    return w;
  endfunction

  function automatic logic m_mis(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    return (a % nbytes(op[1:0])) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input string tag, input logic en, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input logic [4:0] wa,
                        input logic we, input logic [31:0] wd, input int waits);
    logic st = en && op[3];
    logic mis = en && m_mis(op, a);
    logic exp_we = (st || mis) ? 1'b0 : (we && wa != 5'd0);
    logic [31:0] exp_wd = en ? m_load(op, a, rd) : wd;
    @(negedge clk_i);
    chk({tag, ".ready"}, 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1; mem_en_i = en; mem_op_i = op; mem_addr_i = a; mem_data_i = d;
    reg_waddr_i = wa; reg_we_i = we; reg_wdata_i = wd;
    @(negedge clk_i);
    if (en && !mis) begin
      for (int k = 0; k <= waits; k++) begin
        chk({tag, ".req"}, 32'(dbus_req_o), 32'd1);
        chk({tag, ".bwe"}, 32'(dbus_we_o), 32'(st));
        chk({tag, ".baddr"}, dbus_addr_o, a & ~32'd3);
        chk({tag, ".be"}, 32'(dbus_be_o), st ? 32'(m_be(op, a)) : 32'hF);
        if (st) chk({tag, ".bwdata"}, dbus_wdata_o, m_wd(op, d));
        chk({tag, ".busy_ready"}, 32'(in_ready_o), 32'd0);
        chk({tag, ".busy_ov"}, 32'(out_valid_o), 32'd0);
        dbus_ack_i = (k == waits);
        dbus_rdata_i = (k == waits) ? rd : $urandom;
        @(negedge clk_i);
      end
      dbus_ack_i = 1'b0;
      chk({tag, ".req_drop"}, 32'(dbus_req_o), 32'd0);
    end else if (mis) chk({tag, ".no_req"}, 32'(dbus_req_o), 32'd0);
    in_valid_i = 1'b0;
    chk({tag, ".ov"}, 32'(out_valid_o), 32'd1);
    chk({tag, ".waddr"}, 32'(reg_waddr_o), 32'(wa));
    chk({tag, ".we"}, 32'(reg_we_o), 32'(exp_we));
    chk({tag, ".mis"}, 32'(misalign_o), 32'(mis));
    if (!st && !mis) chk({tag, ".wdata"}, reg_wdata_o, exp_wd);
    @(negedge clk_i);
    chk({tag, ".ov_once"}, 32'(out_valid_o), 32'd0);
    if (!st && !mis) chk({tag, ".hold"}, reg_wdata_o, exp_wd);
  endtask

  initial begin
    logic [3:0] op;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst.ready", 32'(in_ready_o), 32'd1);
    chk("rst.ov", 32'(out_valid_o), 32'd0);
    chk("rst.req", 32'(dbus_req_o), 32'd0);
    chk("rst.bwe", 32'(dbus_we_o), 32'd0);
    chk("rst.be", 32'(dbus_be_o), 32'd0);
    chk("rst.mis", 32'(misalign_o), 32'd0);
    chk("rst.we", 32'(reg_we_o), 32'd0);
    chk("rst.waddr", 32'(reg_waddr_o), 32'd0);
    chk("rst.wdata", reg_wdata_o, 32'd0);
    chk("rst.baddr", dbus_addr_o, 32'd0);
    chk("rst.bwdata", dbus_wdata_o, 32'd0);
    run_op("addi", 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 0);
    run_op("lb", 1'b1, 4'b0000, 32'h1003, 32'h0, 32'h80FF_1122, 5'd7, 1'b1, 32'h0, 3);
    run_op("lbu", 1'b1, 4'b0100, 32'h1003, 32'h0, 32'h80FF_1122, 5'd7, 1'b1, 32'h0, 3);
    run_op("sh", 1'b1, 4'b1001, 32'h2002, 32'hABCD_5678, 32'h0, 5'd9, 1'b1, 32'h0, 0);
    run_op("lw0", 1'b1, 4'b0010, 32'h10, 32'h0, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h0, 0);
    run_op("lw1", 1'b1, 4'b0010, 32'h14, 32'h0, 32'h0BAD_F00D, 5'd4, 1'b1, 32'h0, 0);
    run_op("lw_x0", 1'b1, 4'b0010, 32'h20, 32'h0, 32'h1111_2222, 5'd0, 1'b1, 32'h0, 1);
    run_op("lw_mis", 1'b1, 4'b0010, 32'h1001, 32'h0, 32'h5555_AAAA, 5'd6, 1'b1, 32'h0, 0);
    run_op("lh_sz3", 1'b1, 4'b0011, 32'h3000, 32'h0, 32'hCAFE_0001, 5'd8, 1'b1, 32'h0, 0);
    @(negedge clk_i);
    in_valid_i = 1'b1; mem_en_i = 1'b1; mem_op_i = 4'b0010; mem_addr_i = 32'h40; reg_waddr_i = 5'd2;
    @(negedge clk_i);
    chk("rstbusy.req1", 32'(dbus_req_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; in_valid_i = 1'b0;
    chk("rstbusy.req", 32'(dbus_req_o), 32'd0);
    chk("rstbusy.ov", 32'(out_valid_o), 32'd0);
    chk("rstbusy.ready", 32'(in_ready_o), 32'd1);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    dbus_ack_i = 1'b0;
    chk("stray.ov", 32'(out_valid_o), 32'd0);
    chk("stray.req", 32'(dbus_req_o), 32'd0);
    @(negedge clk_i);
    chk("stray.ov2", 32'(out_valid_o), 32'd0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      run_op("rnd", 1'($urandom), op, $urandom, $urandom, $urandom,
             (i % 7 == 0) ? 5'd0 : 5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below.
- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  instruction present from exe_mem
- in_ready_o  out  1  block can accept an instruction this cycle
- reg_waddr_i  in  5  destination register
- reg_we_i  in  1  register write enable
- reg_wdata_i  in  32  ALU result (non-memory ops)
- mem_en_i  in  1  instruction is a load/store
- mem_op_i  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word)
- mem_addr_i  in  32  effective byte address
- mem_data_i  in  32  store data
- dbus_req_o  out  1  data-bus request
- dbus_we_o  out  1  data-bus write
- dbus_addr_o  out  32  word address ({addr[31:2],2'b00})
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_be_o  out  4  byte enables
- dbus_ack_i  in  1  bus completion; dbus_rdata_i valid the same cycle
- dbus_rdata_i  in  32  read word
- out_valid_o  out  1  one-cycle pulse to mem_wb
- reg_waddr_o  out  5; reg_we_o  out  1; reg_wdata_o  out  32  writeback triple
- misalign_o  out  1  misaligned access flag, qualified by out_valid_o

Function
REQ-002 The FSM SHALL have two states, IDLE and BUSY; in_ready_o = (state==IDLE).
REQ-003 In IDLE, in_valid_i with mem_en_i=0 SHALL give out_valid_o=1 on the next cycle, with reg_waddr/we/wdata copied from the inputs (latency 1).
REQ-004 In IDLE, in_valid_i with mem_en_i=1 SHALL capture all inputs, move to BUSY, and assert dbus_req_o from the next cycle.
REQ-005 In BUSY, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o and dbus_be_o SHALL stay constant until dbus_ack_i is sampled high.
REQ-006 On the ack cycle the FSM SHALL return to IDLE, and dbus_req_o SHALL be 0 in the following cycle.
REQ-007 On the ack cycle, out_valid_o SHALL be registered high for the following cycle, giving a minimum memory latency of 2 cycles from acceptance.
REQ-008 in_valid_i SHALL be ignored while in BUSY; upstream holds the instruction while in_ready_o=0.
REQ-009 dbus_ack_i SHALL be ignored in IDLE.
REQ-010 Store byte-enables: SB be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}; SW be=4'b1111, wdata=data.
REQ-011 Loads SHALL have dbus_we_o=0 and be=4'b1111.
REQ-012 Load extraction: byte is selected by addr[1:0], half by addr[1]; the result is sign-extended unless mem_op[2]=1, in which case it is zero-extended.
REQ-013 Stores SHALL drive reg_we_o=0 on out_valid_o; loads SHALL drive reg_we_o=reg_we_i.
REQ-014 Any out_valid_o with reg_waddr_o=0 SHALL force reg_we_o=0; a bus access to x0 still occurs.
REQ-015 out_valid_o SHALL pulse exactly once per accepted instruction and never in consecutive cycles for a single instruction.
REQ-016 Output registers SHALL hold their last values when out_valid_o=0.
REQ-017 Undefined size 2'b11 SHALL be treated as word.

Reset
REQ-018 With rst_i=1 at a clock edge, the block SHALL reach the following state:
- state=IDLE
- out_valid_o=0, dbus_req_o=0, dbus_we_o=0, dbus_be_o=0, misalign_o=0
- reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, dbus_addr_o=0, dbus_wdata_o=0
REQ-019 Reset during BUSY SHALL abandon the access: dbus_req_o=0 in the next cycle, no out_valid_o, and any later stray ack is ignored.

Configuration
REQ-020 Misalignment detection SHALL be compiled in by the macro MEM_MISALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no bus request; out_valid_o pulses the next cycle with misalign_o=1 and reg_we_o=0.
- Undefined: misalign_o SHALL be tied to 0; a word access uses the aligned-down address; a half access ignores addr[0].

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ADDI result, x5, 0x1234, mem_en=0 -> out_valid 1 cycle later with waddr=5, we=1, wdata=0x00001234.
- LB at addr 0x1003, rdata 0x80FF_1122, ack after 3 wait cycles -> req held stable 3 cycles, then reg_wdata=0xFFFFFF80; LBU of the same gives 0x00000080.
- SH 0xABCD_5678 at 0x2002 -> be=4'b1100, wdata=0x56785678, we=1, then out_valid with reg_we=0.
- Back-to-back LW at 0x10 and LW at 0x14, each with immediate ack -> in_ready low one cycle each, two distinct out_valid pulses.
- Reset asserted in the second BUSY cycle, ack arriving afterwards -> req drops, no out_valid.
- With MEM_MISALIGN_CHECK_EN, LW at 0x1001 -> no dbus_req, misalign_o=1, reg_we_o=0; without the macro, the bus address is 0x1000.
